// File: rtl/spi_master_tx.sv
// SPI mode-0 master: shifts one FRAME_BITS word out on MOSI, MSB first, with a start/busy/done handshake.
// Optional MISO capture path is built only when SPI_MASTER_RX_EN is defined; otherwise rx_data reads 0.
module spi_master_tx #(
    parameter int unsigned CLK_DIV    = 25,
    parameter int unsigned FRAME_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  SS,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_HIGH,
        ST_LOW,
        ST_TRAIL,
        ST_GAP
    } state_e;

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BW = $clog2(FRAME_BITS);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    state_e                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ss_q, ss_d;
    logic                  sclk_q, sclk_d;
    logic                  phase_end;
    logic                  rx_shift;
    logic                  rx_load;

    assign phase_end = (phase_q == PH_LAST);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        tx_sr_d  = tx_sr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ss_d     = ss_q;
        sclk_d   = sclk_q;
        rx_shift = 1'b0;
        rx_load  = 1'b0;

        if (state_q == ST_IDLE) begin
            phase_d = '0;
        end else begin
            phase_d = phase_end ? '0 : phase_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_sr_d = tx_data;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    state_d = ST_LEAD;
                end
            end
            ST_LEAD, ST_LOW: begin
                if (phase_end) begin
                    sclk_d   = 1'b1;
                    rx_shift = 1'b1;
                    state_d  = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    sclk_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_TRAIL;
                    end else begin
                        // MOSI is the shift register MSB, so shifting presents the next bit
                        tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
                        bit_d   = bit_q + 1'b1;
                        state_d = ST_LOW;
                    end
                end
            end
            ST_TRAIL: begin
                if (phase_end) begin
                    ss_d    = 1'b1;
                    tx_sr_d = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (phase_end) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rx_load = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            tx_sr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ss_q    <= 1'b1;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            tx_sr_q <= tx_sr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ss_q    <= ss_d;
            sclk_q  <= sclk_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign SS   = ss_q;
    assign SCLK = sclk_q;
    assign MOSI = tx_sr_q[FRAME_BITS-1];

`ifdef SPI_MASTER_RX_EN
    logic [FRAME_BITS-1:0] rx_sr_q, rx_sr_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;

    always_comb begin
        rx_sr_d   = rx_shift ? {rx_sr_q[FRAME_BITS-2:0], MISO} : rx_sr_q;
        rx_data_d = rx_load ? rx_sr_q : rx_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr_q   <= '0;
            rx_data_q <= '0;
        end else begin
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign rx_data = rx_data_q;
`else
    logic unused_rx;
    assign unused_rx = ^{MISO, rx_shift, rx_load};
    assign rx_data   = '0;
`endif

endmodule
